// File: rtl/pll_lock_controller.sv
// Coarse/fine DCO acquisition and lock sequencer driven by PFD up/down pulses.
// Define PLL_LOCK_LOSS_DET_EN to enable lock-loss detection while LOCKED.
module pll_lock_controller #(
  parameter int CTRL_W         = 10,
  parameter int CTRL_INIT      = 512,
  parameter int COARSE_STEP    = 16,
  parameter int LOCK_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LOSS_STREAK    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              up,
  input  logic              down,
  output logic [CTRL_W-1:0] dco_ctrl,
  output logic              locked,
  output logic [1:0]        state,
  output logic              acq_err
);

  localparam int QW = $clog2(LOCK_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CTRL_W:0] MAXV = {1'b0, {CTRL_W{1'b1}}};
  localparam logic [CTRL_W:0] CSTEP = (CTRL_W+1)'(COARSE_STEP);
  localparam logic [CTRL_W:0] FSTEP = (CTRL_W+1)'(1);
  localparam logic [CTRL_W-1:0] INIT = CTRL_W'(CTRL_INIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COARSE = 2'd1,
    S_FINE   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t            r_state, w_nxt;
  logic [CTRL_W-1:0] r_dco, w_dco_nxt;
  logic [CTRL_W-1:0] w_coarse, w_fine;
  logic              r_locked;
  logic              r_err, w_err_nxt;
  logic [1:0]        r_last_dir, w_ld_nxt;
  logic [QW-1:0]     r_quiet, w_quiet_nxt;
  logic [TW-1:0]     r_tmo, w_tmo_nxt;
  logic              w_up, w_dn, w_corr;
  logic              w_match, w_opp, w_tmo_hit;
  logic [1:0]        w_dir;

`ifdef PLL_LOCK_LOSS_DET_EN
  localparam int SW = $clog2(LOSS_STREAK + 1);
  logic [SW-1:0] r_streak, w_streak_nxt;
`else
  logic w_unused_loss;
  assign w_unused_loss = |LOSS_STREAK;
`endif

  // Saturating unsigned step; no wrap at either end.
  function automatic logic [CTRL_W-1:0] f_step(
    input logic [CTRL_W-1:0] v,
    input logic [CTRL_W:0]   s,
    input logic              inc,
    input logic              dec
  );
    logic [CTRL_W:0] e;
    e = {1'b0, v};
    if (inc)
      e = ((e + s) > MAXV) ? MAXV : (e + s);
    else if (dec)
      e = (e < s) ? '0 : (e - s);
    return e[CTRL_W-1:0];
  endfunction

  // last_dir: 2'b01 = up, 2'b10 = down, 2'b00 = none yet.
  assign w_up      = up & ~down;
  assign w_dn      = down & ~up;
  assign w_corr    = w_up | w_dn;
  assign w_dir     = {w_dn, w_up};
  assign w_match   = w_corr && (w_dir == r_last_dir);
  assign w_opp     = w_corr && (r_last_dir != 2'b00)
                     && (w_dir != r_last_dir);
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_coarse  = f_step(r_dco, CSTEP, w_up, w_dn);
  assign w_fine    = f_step(r_dco, FSTEP, w_up, w_dn);

  always_comb begin
    w_nxt       = r_state;
    w_dco_nxt   = r_dco;
    w_ld_nxt    = r_last_dir;
    w_quiet_nxt = '0;
    w_tmo_nxt   = '0;
    w_err_nxt   = r_err;
`ifdef PLL_LOCK_LOSS_DET_EN
    w_streak_nxt = r_streak;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_nxt = S_COARSE;
      end
      S_COARSE: begin
        w_dco_nxt = w_coarse;
        w_tmo_nxt = r_tmo + 1'b1;
        if (w_corr) w_ld_nxt = w_dir;
        if (w_opp) w_nxt = S_FINE;
        if (w_tmo_hit) begin
          w_nxt     = S_IDLE;
          w_err_nxt = 1'b1;
        end
      end
      S_FINE: begin
        w_dco_nxt   = w_fine;
        w_tmo_nxt   = r_tmo + 1'b1;
        w_quiet_nxt = w_match ? '0 : r_quiet + 1'b1;
        if (w_corr) w_ld_nxt = w_dir;
        if (r_quiet == QW'(LOCK_CYCLES - 1))
          w_nxt = S_LOCKED;
        if (w_tmo_hit) begin
          w_nxt     = S_IDLE;
          w_err_nxt = 1'b1;
        end
      end
      S_LOCKED: begin
        w_dco_nxt = w_fine;
        if (w_corr) w_ld_nxt = w_dir;
`ifdef PLL_LOCK_LOSS_DET_EN
        if (w_corr)
          w_streak_nxt = w_match ? r_streak + 1'b1 : SW'(1);
        if (w_streak_nxt == SW'(LOSS_STREAK))
          w_nxt = S_COARSE;
`endif
      end
    endcase
    if (!enable) begin
      w_nxt     = S_IDLE;
      w_err_nxt = 1'b0;
    end
    if (w_nxt != S_FINE) w_quiet_nxt = '0;
    if (w_nxt == S_IDLE || w_nxt == S_LOCKED)
      w_tmo_nxt = '0;
`ifdef PLL_LOCK_LOSS_DET_EN
    if (w_nxt != S_LOCKED) w_streak_nxt = '0;
`endif
    if (w_nxt == S_IDLE || r_state == S_IDLE) begin
      w_dco_nxt = INIT;
      w_ld_nxt  = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dco      <= INIT;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_last_dir <= 2'b00;
      r_quiet    <= '0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_nxt;
      r_dco      <= w_dco_nxt;
      r_locked   <= (w_nxt == S_LOCKED);
      r_err      <= w_err_nxt;
      r_last_dir <= w_ld_nxt;
      r_quiet    <= w_quiet_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

`ifdef PLL_LOCK_LOSS_DET_EN
  always_ff @(posedge clk) begin
    if (rst) r_streak <= '0;
    else     r_streak <= w_streak_nxt;
  end
`endif

  assign dco_ctrl = r_dco;
  assign locked   = r_locked;
  assign state    = r_state;
  assign acq_err  = r_err;

endmodule

// File: tb/tb_pll_lock_controller.sv
// Bench for pll_lock_controller: directed + random pulses vs a reference model.
// Two instances share stimulus: default init and a near-ceiling init.
module tb_pll_lock_controller;

  localparam int LC  = 64;
  localparam int TMO = 4096;
  localparam int LS  = 4;
  localparam int MAXV = 1023;
`ifdef PLL_LOCK_LOSS_DET_EN
  localparam bit LOSS = 1'b1;
`else
  localparam bit LOSS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, enable, up, down;
  logic [9:0] dco0, dco1;
  logic lk0, lk1, err0, err1;
  logic [1:0] st0, st1;

  int nvec  = 0;
  int nfail = 0;

  int m_init [2] = '{512, 1020};
  int m_st   [2];
  int m_dco  [2];
  int m_ld   [2];
  int m_q    [2];
  int m_t    [2];
  int m_s    [2];
  bit m_err  [2];

  always #5 clk = ~clk;

  pll_lock_controller u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .down(down),
    .dco_ctrl(dco0), .locked(lk0), .state(st0), .acq_err(err0)
  );

  pll_lock_controller #(.CTRL_INIT(1020)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .up(up), .down(down),
    .dco_ctrl(dco1), .locked(lk1), .state(st1), .acq_err(err1)
  );

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > MAXV) ? MAXV : v);
  endfunction

  // Reference: acquisition rules evaluated with integer arithmetic.
  function automatic void mstep(input int k, input bit u, input bit dn,
                                input bit en, input bit r);
    int d;
    int ns;
    d  = (u && !dn) ? 1 : ((dn && !u) ? -1 : 0);
    ns = m_st[k];
    if (r || !en) begin
      ns = 0;
      m_err[k] = 1'b0;
    end else begin
      case (m_st[k])
        0: ns = 1;
        1: begin
          if (m_t[k] == TMO - 1) begin
            ns = 0;
            m_err[k] = 1'b1;
          end else begin
            m_dco[k] = sat(m_dco[k] + COARSE(d));
            if (d != 0 && m_ld[k] != 0 && d != m_ld[k]) begin
              ns = 2;
              m_q[k] = 0;
            end
            if (d != 0) m_ld[k] = d;
            m_t[k]++;
          end
        end
        2: begin
          if (m_t[k] == TMO - 1) begin
            ns = 0;
            m_err[k] = 1'b1;
          end else begin
            m_dco[k] = sat(m_dco[k] + d);
            if (m_q[k] == LC - 1) begin
              ns = 3;
              m_t[k] = 0;
              m_s[k] = 0;
            end else if (d != 0 && d == m_ld[k]) begin
              m_q[k] = 0;
              m_t[k]++;
            end else begin
              m_q[k]++;
              m_t[k]++;
            end
            if (d != 0) m_ld[k] = d;
          end
        end
        default: begin
          m_dco[k] = sat(m_dco[k] + d);
          if (LOSS && d != 0) begin
            m_s[k] = (d == m_ld[k]) ? m_s[k] + 1 : 1;
            if (m_s[k] == LS) begin
              ns = 1;
              m_t[k] = 0;
            end
          end
          if (d != 0) m_ld[k] = d;
        end
      endcase
    end
    if (ns == 0) begin
      m_dco[k] = m_init[k];
      m_ld[k] = 0;
      m_q[k] = 0;
      m_t[k] = 0;
      m_s[k] = 0;
    end
    m_st[k] = ns;
  endfunction

  function automatic int COARSE(input int d);
    return 16 * d;
  endfunction

  task automatic chk(input int k, input logic [9:0] d, input logic l,
                     input logic [1:0] s, input logic e);
    assert (d === 10'(m_dco[k])) else begin
      nfail++;
      $error("FAIL dco%0d observed=%0d expected=%0d", k, d, m_dco[k]);
    end
    assert (s === 2'(m_st[k])) else begin
      nfail++;
      $error("FAIL state%0d observed=%0d expected=%0d", k, s, m_st[k]);
    end
    assert (l === (m_st[k] == 3)) else begin
      nfail++;
      $error("FAIL locked%0d observed=%0b expected=%0b", k, l,
             (m_st[k] == 3));
    end
    assert (e === m_err[k]) else begin
      nfail++;
      $error("FAIL acq_err%0d observed=%0b expected=%0b", k, e, m_err[k]);
    end
  endtask

  task automatic lit(input string tag, input int obs, input int exp);
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit u, input bit dn, input bit en, input bit r);
    up = u;
    down = dn;
    enable = en;
    rst = r;
    @(posedge clk);
    mstep(0, u, dn, en, r);
    mstep(1, u, dn, en, r);
    #1;
    nvec++;
    chk(0, dco0, lk0, st0, err0);
    chk(1, dco1, lk1, st1, err1);
  endtask

  initial begin
    int dens;
    up = 0; down = 0; enable = 0; rst = 1;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_dco[k] = m_init[k]; m_ld[k] = 0;
      m_q[k] = 0; m_t[k] = 0; m_s[k] = 0; m_err[k] = 0;
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    lit("reset_dco", int'(dco0), 512);
    lit("reset_state", int'(st0), 0);

    // Coarse: 3 up then a reversing down
    step(0, 0, 1, 0);
    lit("idle_to_coarse", int'(st0), 1);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    lit("coarse_560", int'(dco0), 560);
    lit("ceiling_1023", int'(dco1), 1023);
    step(0, 1, 1, 0);
    lit("reverse_544", int'(dco0), 544);
    lit("reverse_fine", int'(st0), 2);

    // Fine: alternate every 4 cycles until lock
    for (int i = 0; i < 64; i++) begin
      step(i % 8 == 0, i % 8 == 4, 1, 0);
      if (i == 62) lit("not_yet_locked", int'(lk0), 0);
    end
    lit("lock_state", int'(st0), 3);
    lit("lock_flag", int'(lk0), 1);

    // Four downs while locked
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
    lit("streak_dco", int'(dco0), 540);
    lit("streak_locked", int'(lk0), LOSS ? 0 : 1);
    lit("streak_state", int'(st0), LOSS ? 1 : 3);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
    lit("both_hold", int'(dco0), 540);

    // Floor saturation, then timeout
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < TMO; i++) begin
      step(0, 1, 1, 0);
      if (i == 40) lit("floor_0", int'(dco0), 0);
    end
    lit("timeout_err", int'(err0), 1);
    lit("timeout_idle", int'(st0), 0);
    step(0, 1, 1, 0);
    lit("err_sticky", int'(err0), 1);
    step(0, 0, 0, 0);
    lit("err_clear", int'(err0), 0);

    // Enable drop in FINE, rst in LOCKED
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    lit("drop_idle", int'(st0), 0);
    lit("drop_dco", int'(dco0), 512);
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 64; i++) step(0, 0, 1, 0);
    lit("relock", int'(st0), 3);
    step(1, 0, 1, 1);
    lit("rst_idle", int'(st0), 0);
    lit("rst_dco", int'(dco0), 512);

    // Random segments of varying pulse density
    for (int seg = 0; seg < 15; seg++) begin
      case ($urandom_range(0, 2))
        0: dens = 2;
        1: dens = 8;
        default: dens = 40;
      endcase
      for (int i = 0; i < 200; i++)
        step(($urandom % dens) == 0, ($urandom % dens) == 0,
             $urandom_range(0, 299) != 0, $urandom_range(0, 999) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
